// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode/execute pipeline boundary:
// result-source encodings, the bundled control word and the zero register index.
package pipeline_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int REG_ZERO = 0;

    // Every decoded control field that travels from decode into execute
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       jalr;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [2:0] addr_control;
    } ctrl_t;

endpackage

// File: rtl/decode_execute_stage_hazard_unit.sv
// Load-use detection and front-end stall/flush priority resolution.
// Purely combinational; resolved in the same cycle the inputs appear.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      mem_stall,
    input  logic                      pcsrc_e,
    input  logic                      valid_e,
    input  logic                      valid_d,
    input  logic [1:0]                result_src_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    output logic                      lw_stall,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(REG_ZERO);

    // A load in execute whose destination feeds the decode instruction.
    // Rs2 is compared even for opcodes without rs2; the extra stall is harmless.
    always_comb begin
        lw_stall = valid_e & valid_d & (result_src_e == RES_MEM) & (rd_e != ZERO_IDX)
                 & ((rd_e == rs1_d) | (rd_e == rs2_d));
    end

    // Priority: memory freeze, then taken transfer (decode is wrong-path), then load-use
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

endmodule

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register with load-use hazard handling and front-end control.
// Optional build macro PIPE_PERF_COUNTERS_EN adds free-running event counters
// (lw_stall_count, flush_count, mem_stall_count).
module decode_execute_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_stall,
    input  logic                      PCSrcE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic                      ALUSrcD,
    input  logic                      JALRInstrD,
    input  logic [1:0]                ResultSrcD,
    input  logic [3:0]                ALUControlD,
    input  logic [2:0]                AddressingControlD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic                      ALUSrcE,
    output logic                      JALRInstrE,
    output logic [1:0]                ResultSrcE,
    output logic [3:0]                ALUControlE,
    output logic [2:0]                AddressingControlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      ValidE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushD,
    output logic                      FlushE
`ifdef PIPE_PERF_COUNTERS_EN
    ,
    output logic [31:0]               lw_stall_count,
    output logic [31:0]               flush_count,
    output logic [31:0]               mem_stall_count
`endif
);

    ctrl_t                      ctrl_d, ctrl_e;
    logic [DATA_WIDTH-1:0]      rd1_e, rd2_e, pc_e, imm_e, pc4_e;
    logic [REG_ADDR_WIDTH-1:0]  rs1_e, rs2_e, rd_e;
    logic                       valid_e;
    logic                       lw_stall;

    always_comb begin
        ctrl_d = '{reg_write:    RegWriteD,
                   mem_write:    MemWriteD,
                   jump:         JumpD,
                   branch:       BranchD,
                   alu_src:      ALUSrcD,
                   jalr:         JALRInstrD,
                   result_src:   ResultSrcD,
                   alu_control:  ALUControlD,
                   addr_control: AddressingControlD};
    end

    hazard_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .mem_stall    (mem_stall),
        .pcsrc_e      (PCSrcE),
        .valid_e      (valid_e),
        .valid_d      (ValidD),
        .result_src_e (ctrl_e.result_src),
        .rd_e         (rd_e),
        .rs1_d        (Rs1D),
        .rs2_d        (Rs2D),
        .lw_stall     (lw_stall),
        .stall_f      (StallF),
        .stall_d      (StallD),
        .flush_d      (FlushD),
        .flush_e      (FlushE)
    );

    // ID/EX register: hold under memory stall, bubble (all zero) on flush, else load decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e  <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            pc_e    <= '0;
            imm_e   <= '0;
            pc4_e   <= '0;
            rs1_e   <= '0;
            rs2_e   <= '0;
            rd_e    <= '0;
            valid_e <= 1'b0;
        end else if (!mem_stall) begin
            if (FlushE) begin
                ctrl_e  <= '0;
                rd1_e   <= '0;
                rd2_e   <= '0;
                pc_e    <= '0;
                imm_e   <= '0;
                pc4_e   <= '0;
                rs1_e   <= '0;
                rs2_e   <= '0;
                rd_e    <= '0;
                valid_e <= 1'b0;
            end else begin
                ctrl_e  <= ctrl_d;
                rd1_e   <= RD1D;
                rd2_e   <= RD2D;
                pc_e    <= PCD;
                imm_e   <= ImmExtD;
                pc4_e   <= PCPlus4D;
                rs1_e   <= Rs1D;
                rs2_e   <= Rs2D;
                rd_e    <= RdD;
                valid_e <= ValidD;
            end
        end
    end

    assign RegWriteE          = ctrl_e.reg_write;
    assign MemWriteE          = ctrl_e.mem_write;
    assign JumpE              = ctrl_e.jump;
    assign BranchE            = ctrl_e.branch;
    assign ALUSrcE            = ctrl_e.alu_src;
    assign JALRInstrE         = ctrl_e.jalr;
    assign ResultSrcE         = ctrl_e.result_src;
    assign ALUControlE        = ctrl_e.alu_control;
    assign AddressingControlE = ctrl_e.addr_control;
    assign RD1E               = rd1_e;
    assign RD2E               = rd2_e;
    assign PCE                = pc_e;
    assign ImmExtE            = imm_e;
    assign PCPlus4E           = pc4_e;
    assign Rs1E               = rs1_e;
    assign Rs2E               = rs2_e;
    assign RdE                = rd_e;
    assign ValidE             = valid_e;

`ifdef PIPE_PERF_COUNTERS_EN
    // Count the winning priority case each edge; counters wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lw_stall_count  <= '0;
            flush_count     <= '0;
            mem_stall_count <= '0;
        end else begin
            if (mem_stall)
                mem_stall_count <= mem_stall_count + 32'd1;
            if (!mem_stall && PCSrcE)
                flush_count <= flush_count + 32'd1;
            if (!mem_stall && !PCSrcE && lw_stall)
                lw_stall_count <= lw_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed + randomized bench for decode_execute_stage with a cycle-level reference model.
module tb_decode_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_stall = 1'b0, PCSrcE = 1'b0, ValidD = 1'b0;
    logic        RegWriteD = 1'b0, MemWriteD = 1'b0, JumpD = 1'b0, BranchD = 1'b0;
    logic        ALUSrcD = 1'b0, JALRInstrD = 1'b0;
    logic [1:0]  ResultSrcD = '0;
    logic [3:0]  ALUControlD = '0;
    logic [2:0]  AddressingControlD = '0;
    logic [31:0] RD1D = '0, RD2D = '0, PCD = '0, ImmExtD = '0, PCPlus4D = '0;
    logic [4:0]  Rs1D = '0, Rs2D = '0, RdD = '0;

    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  AddressingControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, StallF, StallD, FlushD, FlushE;
`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] lw_stall_count, flush_count, mem_stall_count;
`endif

    int checks = 0;
    int errors = 0;

    decode_execute_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .PCSrcE(PCSrcE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .JALRInstrD(JALRInstrD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .AddressingControlD(AddressingControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .JALRInstrE(JALRInstrE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .AddressingControlE(AddressingControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef PIPE_PERF_COUNTERS_EN
        , .lw_stall_count(lw_stall_count), .flush_count(flush_count),
        .mem_stall_count(mem_stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Contents of the execute slot as the bench expects it
    typedef struct packed {
        logic        v, rw, mw, j, b, as, jalr;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [2:0]  ac;
        logic [31:0] rd1, rd2, pc, imm, pc4;
        logic [4:0]  rs1, rs2, rd;
    } e_t;

    e_t          m_e = '0;
    int unsigned m_lw = 0, m_fl = 0, m_ms = 0;

    function automatic e_t dut_e();
        return '{v: ValidE, rw: RegWriteE, mw: MemWriteE, j: JumpE, b: BranchE, as: ALUSrcE,
                 jalr: JALRInstrE, rs: ResultSrcE, alu: ALUControlE, ac: AddressingControlE,
                 rd1: RD1E, rd2: RD2E, pc: PCE, imm: ImmExtE, pc4: PCPlus4E,
                 rs1: Rs1E, rs2: Rs2E, rd: RdE};
    endfunction

    function automatic e_t d_fields();
        return '{v: ValidD, rw: RegWriteD, mw: MemWriteD, j: JumpD, b: BranchD, as: ALUSrcD,
                 jalr: JALRInstrD, rs: ResultSrcD, alu: ALUControlD, ac: AddressingControlD,
                 rd1: RD1D, rd2: RD2D, pc: PCD, imm: ImmExtD, pc4: PCPlus4D,
                 rs1: Rs1D, rs2: Rs2D, rd: RdD};
    endfunction

    // Does the load in E feed the valid decode instruction?
    function automatic bit model_load_use();
        return m_e.v && ValidD && m_e.rs == 2'b01 && m_e.rd != 0 &&
               (m_e.rd == Rs1D || m_e.rd == Rs2D);
    endfunction

    // Expected {StallF, StallD, FlushD, FlushE}
    function automatic logic [3:0] model_ctl();
        if (mem_stall)             return 4'b1100;
        else if (PCSrcE)           return 4'b0011;
        else if (model_load_use()) return 4'b1101;
        else                       return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_e(input string tag);
        e_t o;
        o = dut_e();
        checks++;
        assert (o === m_e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, m_e);
        end
    endtask

    task automatic chk_ctl(input string tag);
        chk(tag, {60'd0, StallF, StallD, FlushD, FlushE}, {60'd0, model_ctl()});
    endtask

    // One clock edge: advance the model from the inputs present at the edge, then check E
    task automatic step(input string tag);
        logic [3:0] c;
        @(posedge clk);
        c = model_ctl();
        if (mem_stall) m_ms++;
        else if (PCSrcE) m_fl++;
        else if (c[0]) m_lw++;
        if (!mem_stall) m_e = c[0] ? e_t'('0) : d_fields();
        #1;
        chk_e(tag);
    endtask

    task automatic rand_d();
        ValidD = 1'b1;
        {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRInstrD} = 6'($urandom);
        ResultSrcD = 2'($urandom);
        ALUControlD = 4'($urandom);
        AddressingControlD = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom; PCPlus4D = $urandom;
        Rs1D = 5'($urandom_range(0, 3));
        Rs2D = 5'($urandom_range(0, 3));
        RdD  = 5'($urandom_range(0, 3));
    endtask

    // Put "lw rd" into decode
    task automatic load_d(input logic [4:0] rd);
        rand_d();
        ResultSrcD = 2'b01; RdD = rd; RegWriteD = 1'b1;
        Rs1D = 5'd10; Rs2D = 5'd11;
    endtask

    initial begin
        // reset state
        rand_d();
        #12;
        chk_e("reset_state");
        rst_n = 1'b1;

        // async reset mid-cycle with nonzero D fields
        ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1;
        ALUSrcD = 1'b1; JALRInstrD = 1'b1; ResultSrcD = 2'b10; ALUControlD = 4'hf;
        AddressingControlD = 3'h7; RD1D = 32'h1111; RD2D = 32'h2222; PCD = 32'h3333;
        ImmExtD = 32'h4444; PCPlus4D = 32'h3337; Rs1D = 5'd9; Rs2D = 5'd9; RdD = 5'd9;
        step("load_before_reset");
        chk("valid_before_reset", 64'(ValidE), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        m_e = '0; m_lw = 0; m_fl = 0; m_ms = 0;
        chk_e("async_reset_e");
        chk("async_reset_valid", 64'(ValidE), 64'd0);
        #1 rst_n = 1'b1;

        // load-use: lw x5 then add x6,x5,x7
        load_d(5'd5);
        step("lu_lw_enter");
        rand_d(); Rs1D = 5'd5; Rs2D = 5'd7; RdD = 5'd6; ResultSrcD = 2'b00; RegWriteD = 1'b1;
        #1 chk("lu_ctl", {60'd0, StallF, StallD, FlushD, FlushE}, 64'hd);
        step("lu_bubble");
        chk("lu_bubble_rw", {62'd0, RegWriteE, ValidE}, 64'd0);
        #1 chk_ctl("lu_release_ctl");
        step("lu_add_enter");
        chk("lu_add_rd", 64'(RdE), 64'd6);

        // lw x0 in E, Rs1D=0: no stall
        load_d(5'd0);
        step("x0_lw_enter");
        rand_d(); Rs1D = 5'd0; Rs2D = 5'd0;
        #1 chk("x0_no_stall", {60'd0, StallF, StallD, FlushD, FlushE}, 64'd0);
        step("x0_latch");

        // lw x5 in E, invalid decode: no stall
        load_d(5'd5);
        step("inv_lw_enter");
        rand_d(); ValidD = 1'b0; Rs1D = 5'd5; Rs2D = 5'd5;
        #1 chk("inv_no_stall", {60'd0, StallF, StallD, FlushD, FlushE}, 64'd0);
        step("inv_latch");

        // taken transfer overrides load-use
        load_d(5'd5);
        step("br_lw_enter");
        rand_d(); Rs1D = 5'd5; MemWriteD = 1'b1; PCSrcE = 1'b1;
        #1 chk("br_ctl", {60'd0, StallF, StallD, FlushD, FlushE}, 64'h3);
        step("br_bubble");
        chk("br_bubble_vm", {62'd0, ValidE, MemWriteE}, 64'd0);
        PCSrcE = 1'b0;

        // memory stall for 3 cycles with a pending taken transfer
        rand_d();
        step("ms_enter");
        mem_stall = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            #1 chk("ms_flushd", 64'(FlushD), 64'd0);
            chk_ctl("ms_ctl");
            step("ms_hold");
        end
        mem_stall = 1'b0;
        #1 chk("ms_release_flush", {62'd0, FlushD, FlushE}, 64'h3);
        step("ms_release");
        chk("ms_release_valid", 64'(ValidE), 64'd0);
        PCSrcE = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_d();
            ValidD = ($urandom_range(0, 7) != 0);
            mem_stall = ($urandom_range(0, 5) == 0);
            PCSrcE = ($urandom_range(0, 7) == 0);
            #1 chk_ctl("rnd_ctl");
            step("rnd_e");
        end
        mem_stall = 1'b0; PCSrcE = 1'b0;

`ifdef PIPE_PERF_COUNTERS_EN
        #1;
        chk("cnt_lw", 64'(lw_stall_count), 64'(m_lw));
        chk("cnt_flush", 64'(flush_count), 64'(m_fl));
        chk("cnt_mem", 64'(mem_stall_count), 64'(m_ms));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
